// File: rtl/eb_rr_arb_if.sv
// Stream bundle for eb_rr_arb: N upstream valid/ready channels and the registered output stage.
// The slave modport is the arbiter's view; master is the environment driving it.
interface eb_rr_arb_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 32,
  parameter int unsigned SW = $clog2(N)
) ();

  logic [N-1:0]   t_valid;
  logic [N-1:0]   t_ready;
  logic [N*W-1:0] t_data;
  logic [N-1:0]   t_last;
  logic           i_valid;
  logic           i_ready;
  logic [W-1:0]   i_data;
  logic           i_last;
  logic [SW-1:0]  i_src;
  logic           locked;

  modport slave (
    input  t_valid, t_data, t_last, i_ready,
    output t_ready, i_valid, i_data, i_last, i_src, locked
  );

  modport master (
    output t_valid, t_data, t_last, i_ready,
    input  t_ready, i_valid, i_data, i_last, i_src, locked
  );

endinterface

// File: rtl/eb_rr_arb.sv
// Packet-aware N-input round-robin arbiter feeding a single registered elastic output stage.
// A channel that wins keeps the grant until its last beat is accepted.
module eb_rr_arb #(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 32,
  parameter int unsigned SW = $clog2(N)
) (
  input  logic        clk,
  input  logic        reset_n,
  eb_rr_arb_if.slave  bus
);

  logic [SW-1:0] r_ptr;
  logic [SW-1:0] r_owner;
  logic          r_locked;
  logic          r_valid;
  logic [W-1:0]  r_data;
  logic          r_last;
  logic [SW-1:0] r_src;

  logic          w_en;
  logic [N-1:0]  w_grant;
  logic          w_found;
  logic [SW:0]   w_sum;
  logic [SW-1:0] w_idx;
  logic [SW-1:0] w_sel;
  logic [W-1:0]  w_data_sel;
  logic          w_last_sel;
  logic          w_xfer;
  logic [SW-1:0] w_ptr_nxt;

  // Stage can take a beat when empty or draining; gated by reset so no ready leaks while held.
  assign w_en = (~r_valid | bus.i_ready) & reset_n;

  // Grant: locked owner only, otherwise first valid channel searching upward from r_ptr.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    if (r_locked) begin
      w_grant[r_owner] = bus.t_valid[r_owner];
    end else begin
      for (int i = 0; i < N; i++) begin
        w_sum = {1'b0, r_ptr} + (SW+1)'(i);
        if (w_sum >= (SW+1)'(N)) begin
          w_sum = w_sum - (SW+1)'(N);
        end
        w_idx = w_sum[SW-1:0];
        if (!w_found && bus.t_valid[w_idx]) begin
          w_grant[w_idx] = 1'b1;
          w_found        = 1'b1;
        end
      end
    end
  end

  // Encode the one-hot grant and select the winning channel's payload.
  always_comb begin
    w_sel      = '0;
    w_data_sel = '0;
    w_last_sel = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (w_grant[k]) begin
        w_sel      = SW'(k);
        w_data_sel = bus.t_data[k*W +: W];
        w_last_sel = bus.t_last[k];
      end
    end
  end

  assign bus.t_ready = w_grant & {N{w_en}};
  assign w_xfer      = |(bus.t_valid & bus.t_ready);
  assign w_ptr_nxt   = (w_sel == SW'(N-1)) ? '0 : w_sel + SW'(1);

  // Output stage and arbitration state; a new beat replaces a draining one without a bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr    <= '0;
      r_owner  <= '0;
      r_locked <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_last   <= 1'b0;
      r_src    <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_data_sel;
      r_last  <= w_last_sel;
      r_src   <= w_sel;
      if (w_last_sel) begin
        r_locked <= 1'b0;
        r_ptr    <= w_ptr_nxt;
      end else begin
        r_locked <= 1'b1;
        r_owner  <= w_sel;
      end
    end else if (bus.i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.i_valid = r_valid;
  assign bus.i_data  = r_data;
  assign bus.i_last  = r_last;
  assign bus.i_src   = r_src;
  assign bus.locked  = r_locked;

endmodule

// File: tb/tb_eb_rr_arb.sv
// Table-driven bench for eb_rr_arb with a scoreboard of expected output beats.
module tb_eb_rr_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 32;
  localparam int unsigned SW = 2;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  eb_rr_arb_if #(.N(N), .W(W), .SW(SW)) u_if ();

  eb_rr_arb #(.N(N), .W(W), .SW(SW)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if)
  );

  typedef struct {
    logic       rst;  // pulse reset before applying this step
    logic [3:0] tv;
    logic [3:0] tl;
    logic       ir;
    logic [3:0] rdy;  // expected t_ready
    logic       v;    // expected i_valid before the edge
    logic       lk;   // expected locked before the edge
  } vec_t;

  typedef struct {
    logic [W-1:0]  data;
    logic          last;
    logic [SW-1:0] src;
  } beat_t;

  vec_t  vecs[$];
  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;

  function automatic void add(logic rst, logic [3:0] tv, logic [3:0] tl, logic ir,
                              logic [3:0] rdy, logic v, logic lk);
    vec_t e;
    e.rst = rst; e.tv = tv; e.tl = tl; e.ir = ir; e.rdy = rdy; e.v = v; e.lk = lk;
    vecs.push_back(e);
  endfunction

  function automatic logic [W-1:0] pat(int s, int k);
    return {8'(k), 8'hC3, 16'(s)};
  endfunction

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Asynchronous reset pulse in the middle of traffic; returns on a falling clock edge.
  task automatic do_reset(int s);
    #1 reset_n = 1'b0;
    #1;
    check($sformatf("rst%0d_valid", s), W'(u_if.i_valid), '0);
    check($sformatf("rst%0d_locked", s), W'(u_if.locked), '0);
    check($sformatf("rst%0d_ready", s), W'(u_if.t_ready), '0);
    check($sformatf("rst%0d_data", s), u_if.i_data, '0);
    check($sformatf("rst%0d_src", s), W'(u_if.i_src), '0);
    @(posedge clk);
    #1;
    check($sformatf("rst%0d_ready_hold", s), W'(u_if.t_ready), '0);
    check($sformatf("rst%0d_valid_hold", s), W'(u_if.i_valid), '0);
    @(negedge clk);
    sb.delete();
    reset_n = 1'b1;
  endtask

  task automatic run_vec(int s, vec_t v);
    beat_t b;
    int    k_win;
    if (v.rst) do_reset(s);
    u_if.t_valid = v.tv;
    u_if.t_last  = v.tl;
    u_if.i_ready = v.ir;
    for (int k = 0; k < N; k++) u_if.t_data[k*W +: W] = pat(s, k);
    #1;
    check($sformatf("s%0d_t_ready", s), W'(u_if.t_ready), W'(v.rdy));
    check($sformatf("s%0d_i_valid", s), W'(u_if.i_valid), W'(v.v));
    check($sformatf("s%0d_locked", s), W'(u_if.locked), W'(v.lk));
    if (v.v && v.ir) begin
      if (sb.size() == 0) begin
        check($sformatf("s%0d_sb_empty", s), W'(1), W'(0));
      end else begin
        b = sb.pop_front();
        check($sformatf("s%0d_i_data", s), u_if.i_data, b.data);
        check($sformatf("s%0d_i_last", s), W'(u_if.i_last), W'(b.last));
        check($sformatf("s%0d_i_src", s), W'(u_if.i_src), W'(b.src));
      end
    end
    if ((v.rdy & v.tv) != 4'b0) begin
      k_win = 0;
      for (int k = 0; k < N; k++) if (v.rdy[k] & v.tv[k]) k_win = k;
      b.data = pat(s, k_win);
      b.last = v.tl[k_win];
      b.src  = SW'(k_win);
      sb.push_back(b);
    end
    @(negedge clk);
  endtask

  initial begin
    // Round robin, all valid, single-beat packets: 0,1,2,3,0,1
    add(0, 4'hF, 4'hF, 1, 4'b0001, 0, 0);
    add(0, 4'hF, 4'hF, 1, 4'b0010, 1, 0);
    add(0, 4'hF, 4'hF, 1, 4'b0100, 1, 0);
    add(0, 4'hF, 4'hF, 1, 4'b1000, 1, 0);
    add(0, 4'hF, 4'hF, 1, 4'b0001, 1, 0);
    add(0, 4'hF, 4'hF, 1, 4'b0010, 1, 0);
    // ch2 three-beat packet while others valid, then ch3
    add(0, 4'hF, 4'b1011, 1, 4'b0100, 1, 0);
    add(0, 4'hF, 4'b1011, 1, 4'b0100, 1, 1);
    add(0, 4'hF, 4'hF,    1, 4'b0100, 1, 1);
    add(0, 4'hF, 4'hF,    1, 4'b1000, 1, 0);
    // Five stall cycles, then drain and fill together
    for (int i = 0; i < 5; i++) add(0, 4'hF, 4'hF, 0, 4'b0000, 1, 0);
    add(0, 4'hF, 4'hF, 1, 4'b0001, 1, 0);
    // ch1 owner gap with ch0 valid throughout
    add(0, 4'b0011, 4'b1101, 1, 4'b0010, 1, 0);
    add(0, 4'b0001, 4'hF,    1, 4'b0000, 1, 1);
    add(0, 4'b0001, 4'hF,    1, 4'b0000, 0, 1);
    add(0, 4'b0001, 4'hF,    1, 4'b0000, 0, 1);
    add(0, 4'b0011, 4'hF,    1, 4'b0010, 0, 1);
    add(0, 4'b0001, 4'hF,    1, 4'b0001, 1, 0);
    add(0, 4'b0000, 4'hF,    1, 4'b0000, 1, 0);
    add(0, 4'b0000, 4'hF,    1, 4'b0000, 0, 0);
    // Start a multi-beat packet, reset mid-packet, then sparse ch3 with ptr back at 0
    add(0, 4'hF,    4'b0000, 1, 4'b0010, 0, 0);
    add(1, 4'b1000, 4'b0000, 1, 4'b1000, 0, 0);
    add(0, 4'b1000, 4'b1000, 1, 4'b1000, 1, 1);
    add(0, 4'hF,    4'hF,    1, 4'b0001, 1, 0);
    // Lock again, reset, first grant after release is ch0
    add(0, 4'hF,    4'b0000, 1, 4'b0010, 1, 0);
    add(1, 4'hF,    4'hF,    1, 4'b0001, 0, 0);
    add(0, 4'b0000, 4'hF,    1, 4'b0000, 1, 0);
    add(0, 4'b0000, 4'hF,    1, 4'b0000, 0, 0);

    reset_n      = 1'b0;
    u_if.t_valid = '0;
    u_if.t_last  = '0;
    u_if.t_data  = '0;
    u_if.i_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_valid", W'(u_if.i_valid), '0);
    check("reset_locked", W'(u_if.locked), '0);
    check("reset_src", W'(u_if.i_src), '0);
    reset_n = 1'b1;

    for (int s = 0; s < vecs.size(); s++) run_vec(s, vecs[s]);

    check("sb_drained", W'(sb.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eb_rr_arb.md
Name: eb_rr_arb

Overview:
- N-input round-robin arbiter merging N valid/ready streams into one registered elastic-buffer output stage.
- Packet-aware: once a channel wins, the grant is held until that channel's beat with last=1 is accepted.
- Sits in front of a shared downstream pipeline. Full throughput, 1-cycle latency.

Parameters:
- N, 4, number of requesting channels (N >= 2)
- W, 32, data width per channel
- SW, $clog2(N), width of the source-index output

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- t_valid  input  N  per-channel valid
- t_ready  output  N  per-channel ready (combinational)
- t_data  input  N*W  channel k data at bits [k*W +: W]
- t_last  input  N  per-channel end-of-packet marker
- i_valid  output  1  output stage valid (registered)
- i_ready  input  1  downstream ready
- i_data  output  W  registered data
- i_last  output  1  registered last
- i_src  output  SW  registered index of the channel that produced the beat
- locked  output  1  high while a multi-beat packet is in progress (registered)

Behaviour:
- Reset: reset_n is asynchronous and active-low. In reset: i_valid=0, i_data=0, i_last=0, i_src=0, locked=0, internal pointer ptr=0, owner=0.
- Stage enable: en = ~i_valid | i_ready. The output register accepts a new beat only when en=1.
- Grant when not locked: combinational round-robin search over t_valid. Search starts at index ptr, then ptr+1 and onward, wrapping modulo N. The first asserted channel k gets grant[k]=1. At most one grant bit is set.
- Grant when locked: grant[owner] = t_valid[owner]. All other channels are ignored even if valid.
- Ready: t_ready[k] = grant[k] & en. At most one t_ready bit is high per cycle. t_ready never depends on t_valid of other channels while locked.
- Transfer on channel k: t_valid[k] & t_ready[k]. On the next edge:
  - i_valid=1, i_data=t_data[k], i_last=t_last[k], i_src=k.
  - If t_last[k]=0: locked<=1, owner<=k.
  - If t_last[k]=1: locked<=0, ptr<=(k+1) mod N.
- No transfer and i_ready=1: i_valid<=0. Data, last and src hold their values; they are don't-care when i_valid=0.
- Stall (i_valid & ~i_ready): i_valid, i_data, i_last and i_src are held stable. No t_ready is asserted.
- Simultaneous drain and fill (i_valid & i_ready with a transfer): the new beat replaces the old one in the same edge, with no bubble. This gives full throughput of 1 beat/cycle.
- Owner gap: if the owner drops t_valid mid-packet, the arbiter stays locked and emits bubbles. The lock is never released without the owner's last beat.
- ptr advances only on an accepted last beat. A single-beat packet (last=1 on the first beat) never sets locked.
- Fairness: with all channels continuously valid and sending 1-beat packets, the grant order is 0,1,2,…,N-1,0,…
- Reset mid-packet: locked and ptr clear immediately. Any beat held in the output stage is dropped (i_valid=0).
- Latency: t transfer to i_valid is 1 cycle.

Test Plan:
- Reset: assert reset_n=0 mid-traffic -> i_valid=0, locked=0, t_ready=0 while reset is low. The first grant after release goes to channel 0 when all channels are valid.
- Round robin: N=4, all t_valid=1 with t_last=1, i_ready=1 -> i_src sequence 0,1,2,3,0,1 on consecutive cycles, i_valid stays 1.
- Packet lock: ch2 sends a 3-beat packet (last on beat 3) while ch0, ch1 and ch3 are valid -> i_src=2,2,2. locked=1 for 2 cycles, then the next grant goes to ch3.
- Backpressure: hold i_ready=0 for 5 cycles with i_valid=1 -> i_data/i_last/i_src stable, all t_ready=0. When i_ready rises, a new beat is loaded the same cycle.
- Owner gap: ch1 sends beat 1 (last=0), drops valid for 3 cycles, then sends beat 2 (last=1), while ch0 stays valid -> 3 bubble cycles (i_valid=0), no ch0 beat between ch1 beats, then ch0 is granted.
- Sparse: only ch3 is valid, ptr=0 -> ch3 granted immediately. ptr becomes 0 after its last beat.
